// File: rtl/traffic_pkg.sv
// Shared widths and defaults for the car tally and the light controller.
package traffic_pkg;

  localparam int unsigned COUNT_W                = 6;
  localparam int unsigned DIGIT_W                = 4;
  localparam int unsigned MAX_COUNT_DEFAULT      = 60;
  localparam int unsigned OVERFLOW_LIMIT_DEFAULT = 5;

  typedef struct packed {
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
  } bcd_t;

  function automatic bcd_t bcd_inc(input bcd_t v);
    bcd_t r;
    r = v;
    if (v.ones == DIGIT_W'(9)) begin
      r.ones = '0;
      r.tens = v.tens + DIGIT_W'(1);
    end else begin
      r.ones = v.ones + DIGIT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/tally_channel.sv
// One sensor channel: 2-flop synchroniser, falling-edge detect, binary + BCD car counter.
module tally_channel
  import traffic_pkg::*;
#(
  parameter int unsigned MAX_COUNT = MAX_COUNT_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ir_i,
  input  logic               clear_i,
  input  logic               sat_i,
  output logic               hit_max_o,
  output logic [COUNT_W-1:0] count_o,
  output logic [DIGIT_W-1:0] ones_o,
  output logic [DIGIT_W-1:0] tens_o
);

  localparam logic [COUNT_W:0] MaxVal = (COUNT_W + 1)'(MAX_COUNT);

  logic               s1_q, s2_q, prev_q;
  logic               evt;
  logic               at_max;
  logic [COUNT_W-1:0] count_q, count_d;
  bcd_t               bcd_q, bcd_d;

  // Sensor is active-low, so a car arriving is a 1 -> 0 transition.
  assign evt       = prev_q & ~s2_q;
  assign at_max    = ({1'b0, count_q} == MaxVal);
  assign hit_max_o = evt & (({1'b0, count_q} + (COUNT_W + 1)'(1)) == MaxVal);

  always_comb begin
    count_d = count_q;
    bcd_d   = bcd_q;
    if (clear_i) begin
      count_d = '0;
      bcd_d   = '0;
    end else if (evt && !(sat_i && at_max)) begin
      count_d = count_q + COUNT_W'(1);
      bcd_d   = bcd_inc(bcd_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      prev_q  <= 1'b1;
      count_q <= '0;
      bcd_q   <= '0;
    end else begin
      s1_q    <= ir_i;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      count_q <= count_d;
      bcd_q   <= bcd_d;
    end
  end

  assign count_o = count_q;
  assign ones_o  = bcd_q.ones;
  assign tens_o  = bcd_q.tens;

endmodule

// File: rtl/traffic_tally.sv
// Per-direction car tally with shared wrap and snapshot of heavy-direction flags.
// Build option TRAFFIC_TALLY_SATURATE_EN: channels saturate independently, no wrap.
module traffic_tally
  import traffic_pkg::*;
#(
  parameter int unsigned MAX_COUNT      = MAX_COUNT_DEFAULT,
  parameter int unsigned OVERFLOW_LIMIT = OVERFLOW_LIMIT_DEFAULT
) (
  input  logic               clk_1hz,
  input  logic               reset_counts,
  input  logic               ud_ir_i,
  input  logic               lr_ir_i,
  input  logic               snap_i,
  output logic [COUNT_W-1:0] ud_count_o,
  output logic [COUNT_W-1:0] lr_count_o,
  output logic [DIGIT_W-1:0] ud_ones_o,
  output logic [DIGIT_W-1:0] ud_tens_o,
  output logic [DIGIT_W-1:0] lr_ones_o,
  output logic [DIGIT_W-1:0] lr_tens_o,
  output logic               ud_heavy_o,
  output logic               lr_heavy_o,
  output logic               wrap_pulse_o
);

  localparam logic [COUNT_W:0] OvfLim = (COUNT_W + 1)'(OVERFLOW_LIMIT);

  logic             ud_hit, lr_hit;
  logic             clear, sat;
  logic             ud_heavy_q, lr_heavy_q, wrap_pulse_q;
  logic [COUNT_W:0] ud_ext, lr_ext;

`ifdef TRAFFIC_TALLY_SATURATE_EN
  assign sat   = 1'b1;
  assign clear = 1'b0;
`else
  assign sat   = 1'b0;
  // Clear has priority in the channel, so a same-edge event on the other side is dropped.
  assign clear = ud_hit | lr_hit;
`endif

  tally_channel #(
    .MAX_COUNT (MAX_COUNT)
  ) u_ud (
    .clk_i     (clk_1hz),
    .rst_i     (reset_counts),
    .ir_i      (ud_ir_i),
    .clear_i   (clear),
    .sat_i     (sat),
    .hit_max_o (ud_hit),
    .count_o   (ud_count_o),
    .ones_o    (ud_ones_o),
    .tens_o    (ud_tens_o)
  );

  tally_channel #(
    .MAX_COUNT (MAX_COUNT)
  ) u_lr (
    .clk_i     (clk_1hz),
    .rst_i     (reset_counts),
    .ir_i      (lr_ir_i),
    .clear_i   (clear),
    .sat_i     (sat),
    .hit_max_o (lr_hit),
    .count_o   (lr_count_o),
    .ones_o    (lr_ones_o),
    .tens_o    (lr_tens_o)
  );

  assign ud_ext = {1'b0, ud_count_o};
  assign lr_ext = {1'b0, lr_count_o};

  always_ff @(posedge clk_1hz or posedge reset_counts) begin
    if (reset_counts) begin
      ud_heavy_q   <= 1'b0;
      lr_heavy_q   <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else begin
      wrap_pulse_q <= clear;
      if (snap_i) begin
        ud_heavy_q <= (ud_ext >= lr_ext + OvfLim);
        lr_heavy_q <= (lr_ext >= ud_ext + OvfLim);
      end
    end
  end

  assign ud_heavy_o   = ud_heavy_q;
  assign lr_heavy_o   = lr_heavy_q;
  assign wrap_pulse_o = wrap_pulse_q;

endmodule

// File: tb/tb_traffic_tally.sv
// Directed bench for traffic_tally: latency, BCD, simultaneous cars, wrap, snap, async reset.
module tb_traffic_tally;

  logic       clk_1hz = 1'b0;
  logic       reset_counts;
  logic       ud_ir, lr_ir, snap;
  logic [5:0] ud_count, lr_count;
  logic [3:0] ud_ones, ud_tens, lr_ones, lr_tens;
  logic       ud_heavy, lr_heavy, wrap_pulse;

  int checks = 0;
  int errors = 0;

  traffic_tally dut (
    .clk_1hz      (clk_1hz),
    .reset_counts (reset_counts),
    .ud_ir_i      (ud_ir),
    .lr_ir_i      (lr_ir),
    .snap_i       (snap),
    .ud_count_o   (ud_count),
    .lr_count_o   (lr_count),
    .ud_ones_o    (ud_ones),
    .ud_tens_o    (ud_tens),
    .lr_ones_o    (lr_ones),
    .lr_tens_o    (lr_tens),
    .ud_heavy_o   (ud_heavy),
    .lr_heavy_o   (lr_heavy),
    .wrap_pulse_o (wrap_pulse)
  );

  always #5 clk_1hz = ~clk_1hz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_1hz);
    #1;
  endtask

  task automatic car(input logic u, input logic l);
    ud_ir = ~u;
    lr_ir = ~l;
    tick();
    ud_ir = 1'b1;
    lr_ir = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    reset_counts = 1'b1;
    #3;
    reset_counts = 1'b0;
  endtask

  task automatic check_counts(input string tag, input int u, input int l);
    check({tag, " ud_count"}, 32'(ud_count), 32'(u));
    check({tag, " lr_count"}, 32'(lr_count), 32'(l));
  endtask

  initial begin
    reset_counts = 1'b1;
    ud_ir = 1'b1;
    lr_ir = 1'b1;
    snap  = 1'b0;
    #2;
    check("rst ud_count", 32'(ud_count), 0);
    check("rst lr_count", 32'(lr_count), 0);
    check("rst ud_heavy", 32'(ud_heavy), 0);
    check("rst wrap", 32'(wrap_pulse), 0);
    #10;
    reset_counts = 1'b0;

    // Idle for 10 ticks.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle wrap", 32'(wrap_pulse), 0);
    end
    check_counts("idle", 0, 0);
    check("idle ud_ones", 32'(ud_ones), 0);
    check("idle ud_tens", 32'(ud_tens), 0);
    check("idle lr_ones", 32'(lr_ones), 0);
    check("idle lr_tens", 32'(lr_tens), 0);
    check("idle ud_heavy", 32'(ud_heavy), 0);
    check("idle lr_heavy", 32'(lr_heavy), 0);

    // First car latency: update lands two edges after the first low sample.
    ud_ir = 1'b0;
    tick();
    ud_ir = 1'b1;
    check("lat edge k", 32'(ud_count), 0);
    tick();
    check("lat edge k+1", 32'(ud_count), 0);
    tick();
    check("lat edge k+2", 32'(ud_count), 1);

    for (int i = 0; i < 11; i++) car(1'b1, 1'b0);
    tick();
    check_counts("12 cars", 12, 0);
    check("12 ud_tens", 32'(ud_tens), 1);
    check("12 ud_ones", 32'(ud_ones), 2);

    // Held-low sensor counts once.
    ud_ir = 1'b0;
    repeat (5) tick();
    ud_ir = 1'b1;
    repeat (3) tick();
    check("hold ud_count", 32'(ud_count), 13);

    // Both sensors in the same tick.
    ud_ir = 1'b0;
    lr_ir = 1'b0;
    tick();
    ud_ir = 1'b1;
    lr_ir = 1'b1;
    tick();
    check_counts("both pre", 13, 0);
    tick();
    check_counts("both post", 14, 1);
    check("both ud_ones", 32'(ud_ones), 4);

    // Snap: ud=7 lr=3 gives no flag, snap on the 7->8 edge uses 7.
    do_reset();
    for (int i = 0; i < 3; i++) car(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) car(1'b1, 1'b0);
    tick();
    check_counts("snap setup", 7, 3);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    check("snap7 ud_heavy", 32'(ud_heavy), 0);
    check("snap7 lr_heavy", 32'(lr_heavy), 0);
    car(1'b1, 1'b0);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    check("snap same edge ud_count", 32'(ud_count), 8);
    check("snap same edge ud_heavy", 32'(ud_heavy), 0);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    check("snap8 ud_heavy", 32'(ud_heavy), 1);
    check("snap8 lr_heavy", 32'(lr_heavy), 0);
    repeat (3) tick();
    check("snap hold ud_heavy", 32'(ud_heavy), 1);

    // lr leads by exactly the limit.
    do_reset();
    check("rst clears ud_heavy", 32'(ud_heavy), 0);
    for (int i = 0; i < 5; i++) car(1'b0, 1'b1);
    tick();
    snap = 1'b1;
    tick();
    snap = 1'b0;
    check("snap lr5 lr_heavy", 32'(lr_heavy), 1);
    check("snap lr5 ud_heavy", 32'(ud_heavy), 0);

    // Wrap: ud to 59, lr 3, then one car on each side together.
    do_reset();
    for (int i = 0; i < 3; i++) car(1'b0, 1'b1);
    for (int i = 0; i < 59; i++) car(1'b1, 1'b0);
    tick();
    check_counts("pre wrap", 59, 3);
    check("pre wrap ud_tens", 32'(ud_tens), 5);
    check("pre wrap ud_ones", 32'(ud_ones), 9);
    check("pre wrap pulse", 32'(wrap_pulse), 0);
    car(1'b1, 1'b1);
    tick();
`ifdef TRAFFIC_TALLY_SATURATE_EN
    check_counts("sat", 60, 4);
    check("sat ud_tens", 32'(ud_tens), 6);
    check("sat ud_ones", 32'(ud_ones), 0);
    check("sat pulse", 32'(wrap_pulse), 0);
    car(1'b1, 1'b0);
    tick();
    check_counts("sat hold", 60, 4);
    check("sat hold pulse", 32'(wrap_pulse), 0);
`else
    check_counts("wrap", 0, 0);
    check("wrap ud_tens", 32'(ud_tens), 0);
    check("wrap ud_ones", 32'(ud_ones), 0);
    check("wrap pulse", 32'(wrap_pulse), 1);
    tick();
    check("wrap pulse drop", 32'(wrap_pulse), 0);
    car(1'b1, 1'b0);
    tick();
    check_counts("post wrap", 1, 0);
    check("post wrap pulse", 32'(wrap_pulse), 0);
`endif

    // Async reset mid-tick with 25/14 and an event in flight.
    do_reset();
    for (int i = 0; i < 14; i++) car(1'b1, 1'b1);
    for (int i = 0; i < 11; i++) car(1'b1, 1'b0);
    tick();
    check_counts("pre async", 25, 14);
    check("pre async ud_tens", 32'(ud_tens), 2);
    check("pre async lr_ones", 32'(lr_ones), 4);
    ud_ir = 1'b0;
    tick();
    ud_ir = 1'b1;
    tick();
    #2;
    reset_counts = 1'b1;
    #1;
    check_counts("async", 0, 0);
    check("async ud_ones", 32'(ud_ones), 0);
    check("async ud_tens", 32'(ud_tens), 0);
    check("async lr_ones", 32'(lr_ones), 0);
    #1;
    reset_counts = 1'b0;
    repeat (3) tick();
    check_counts("async lost event", 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
